// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction type codes, field bit positions and per-type
// register-usage helpers shared by the decode stage and its scoreboard.
package cpu_pkg;

    // Instruction type codes (instruction bits [4:0])
    localparam logic [4:0] TYPE_NOP   = 5'd0;
    localparam logic [4:0] TYPE_ALU   = 5'd1;
    localparam logic [4:0] TYPE_LOAD  = 5'd2;
    localparam logic [4:0] TYPE_STORE = 5'd3;
    localparam logic [4:0] TYPE_JUMP  = 5'd4;
    localparam logic [4:0] TYPE_HALT  = 5'd5;

    // Field bit positions within the 32-bit instruction word
    localparam int TYPE_LSB = 0;
    localparam int TYPE_MSB = 4;
    localparam int RD_LSB   = 5;
    localparam int RD_MSB   = 9;
    localparam int RS1_LSB  = 10;
    localparam int RS1_MSB  = 14;
    localparam int RS2_LSB  = 15;
    localparam int RS2_MSB  = 19;
    localparam int IMM_LSB  = 20;
    localparam int IMM_MSB  = 31;

    // Decoded operation as held in the decode->execute register
    typedef struct packed {
        logic        valid;
        logic [4:0]  op_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } ex_op_t;

    // Type codes above HALT are undefined
    function automatic logic is_legal(input logic [4:0] t);
        return (t <= TYPE_HALT);
    endfunction

    // Types that produce a register result in rd
    function automatic logic writes_rd(input logic [4:0] t);
        return (t == TYPE_ALU) || (t == TYPE_LOAD);
    endfunction

    // Types that consume rs1 (JUMP uses it as the condition)
    function automatic logic reads_rs1(input logic [4:0] t);
        return (t == TYPE_ALU) || (t == TYPE_LOAD) ||
               (t == TYPE_STORE) || (t == TYPE_JUMP);
    endfunction

    // Types that consume rs2 (JUMP uses it as the target address)
    function automatic logic reads_rs2(input logic [4:0] t);
        return (t == TYPE_ALU) || (t == TYPE_STORE) || (t == TYPE_JUMP);
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: pending-write mask for the decode stage.
// A bit is set when a register-writing instruction issues and cleared when
// writeback retires that register. Reports RAW/WAW hazards for the
// instruction currently in decode.
// Optional feature macro: STAGE_DECODE_WB_BYPASS_EN -- a same-cycle
// writeback is treated as already retired when evaluating hazards.
module decode_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       chk_rd,
    input  logic       chk_rs1,
    input  logic       chk_rs2,
    input  logic       set_en,
    input  logic       wb_valid,
    input  logic [4:0] wb_reg,
    output logic       hazard
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_next;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_pend_eff;

    // Per-register set/clear strobes; r0 is never marked pending
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_bits
            assign w_set[gi] = set_en && (rd == 5'(gi)) && (gi != 0);
            assign w_clr[gi] = wb_valid && (wb_reg == 5'(gi));
        end
    endgenerate

    // Next mask: clear retired registers, then set newly issued writers (set wins)
    always_comb begin
        w_pending_next = (r_pending & ~w_clr) | w_set;
    end

    // Pending mask register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // View of the mask used for hazard evaluation
    always_comb begin
`ifdef STAGE_DECODE_WB_BYPASS_EN
        w_pend_eff = r_pending & ~w_clr;
`else
        w_pend_eff = r_pending;
`endif
    end

    // RAW on either source, or WAW on the destination
    always_comb begin
        hazard = (chk_rs1 && w_pend_eff[rs1]) ||
                 (chk_rs2 && w_pend_eff[rs2]) ||
                 (chk_rd  && w_pend_eff[rd]);
    end

endmodule

// File: rtl/stage_decode.sv
// stage_decode: second pipeline stage. Splits the fetch issue-register
// instruction into fields, checks the pending-write scoreboard, holds
// fetch on hazards/execute backpressure/halt, and loads the
// decode->execute register (a bubble when decode must hold).
// Optional feature macro: STAGE_DECODE_WB_BYPASS_EN (see decode_scoreboard).
module stage_decode
    import cpu_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] current_instruction,
    input  logic [31:0] pc_in,
    input  logic        ex_stall,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    output logic [4:0]  current_instruction_type,
    output logic        stall,
    output logic        ex_valid,
    output logic [4:0]  ex_type,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic        halted,
    output logic        illegal
);

    logic [4:0]  w_type;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;
    logic        w_legal;
    logic        w_hazard;
    logic        w_stall;
    logic        w_issue;
    ex_op_t      w_issue_op;
    ex_op_t      r_ex;
    logic        r_halted;
    logic        r_illegal;

    // Field extraction
    assign w_type  = current_instruction[TYPE_MSB:TYPE_LSB];
    assign w_rd    = current_instruction[RD_MSB:RD_LSB];
    assign w_rs1   = current_instruction[RS1_MSB:RS1_LSB];
    assign w_rs2   = current_instruction[RS2_MSB:RS2_LSB];
    assign w_imm   = {{20{current_instruction[IMM_MSB]}}, current_instruction[IMM_MSB:IMM_LSB]};
    assign w_legal = is_legal(w_type);

    assign current_instruction_type = w_type;

    decode_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rd       (w_rd),
        .rs1      (w_rs1),
        .rs2      (w_rs2),
        .chk_rd   (writes_rd(w_type)),
        .chk_rs1  (reads_rs1(w_type)),
        .chk_rs2  (reads_rs2(w_type)),
        .set_en   (w_issue && writes_rd(w_type)),
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .hazard   (w_hazard)
    );

    assign w_stall = w_hazard || ex_stall || r_halted;
    assign w_issue = !w_stall;
    assign stall   = w_stall;

    // Operation loaded on issue; an illegal type becomes a NOP at the same address
    always_comb begin
        w_issue_op    = '0;
        w_issue_op.pc = pc_in - 32'd1;
        if (w_legal) begin
            w_issue_op.valid   = (w_type != TYPE_NOP);
            w_issue_op.op_type = w_type;
            w_issue_op.rd      = w_rd;
            w_issue_op.rs1     = w_rs1;
            w_issue_op.rs2     = w_rs2;
            w_issue_op.imm     = w_imm;
        end
    end

    // Decode->execute register: issue, bubble when holding, or freeze under ex_stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex <= '0;
        end else if (w_issue) begin
            r_ex <= w_issue_op;
        end else if (!ex_stall) begin
            r_ex <= '0;
        end
    end

    // Sticky status flags, set only by an instruction that actually issues
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_issue && (w_type == TYPE_HALT)) begin
                r_halted <= 1'b1;
            end
            if (w_issue && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign ex_valid = r_ex.valid;
    assign ex_type  = r_ex.op_type;
    assign ex_rd    = r_ex.rd;
    assign ex_rs1   = r_ex.rs1;
    assign ex_rs2   = r_ex.rs2;
    assign ex_imm   = r_ex.imm;
    assign ex_pc    = r_ex.pc;
    assign halted   = r_halted;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_stage_decode.sv
// tb_stage_decode: scoreboard bench for stage_decode. Each step drives one
// decode-cycle of inputs, pushes the expected execute-register contents,
// checks the combinational stall at the falling edge and pops/compares the
// execute register just after the next rising edge.
module tb_stage_decode;

    typedef struct packed {
        logic        v;
        logic [4:0]  t;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    localparam int K_ISSUE  = 0;
    localparam int K_BUBBLE = 1;
    localparam int K_HOLD   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_instruction;
    logic [31:0] pc_in;
    logic        ex_stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [4:0]  current_instruction_type;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  ex_type;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic        halted;
    logic        illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t last_exp;

    stage_decode #(.NREGS(32)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .current_instruction      (current_instruction),
        .pc_in                    (pc_in),
        .ex_stall                 (ex_stall),
        .wb_valid                 (wb_valid),
        .wb_reg                   (wb_reg),
        .current_instruction_type (current_instruction_type),
        .stall                    (stall),
        .ex_valid                 (ex_valid),
        .ex_type                  (ex_type),
        .ex_rd                    (ex_rd),
        .ex_rs1                   (ex_rs1),
        .ex_rs2                   (ex_rs2),
        .ex_imm                   (ex_imm),
        .ex_pc                    (ex_pc),
        .halted                   (halted),
        .illegal                  (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference decode of one issuing instruction
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e    = '0;
        e.pc = pc - 32'd1;
        if (ins[4:0] <= 5'd5) begin
            e.v   = (ins[4:0] != 5'd0);
            e.t   = ins[4:0];
            e.rd  = ins[9:5];
            e.rs1 = ins[14:10];
            e.rs2 = ins[19:15];
            e.imm = {{20{ins[31]}}, ins[31:20]};
        end
        return e;
    endfunction

    // One decode cycle: drive, check stall, then compare the execute register
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic exs,
                        input logic wbv, input logic [4:0] wbr, input logic exp_stall,
                        input int kind, input string name);
        exp_t e;
        exp_t got;
        current_instruction = ins;
        pc_in    = pc;
        ex_stall = exs;
        wb_valid = wbv;
        wb_reg   = wbr;
        if (kind == K_ISSUE)       e = model(ins, pc);
        else if (kind == K_BUBBLE) e = '0;
        else                       e = last_exp;
        exp_q.push_back(e);
        #4;
        n_checks++;
        if (stall !== exp_stall) begin
            n_fail++;
            $display("FAIL %s stall: got %b required %b", name, stall, exp_stall);
        end
        @(posedge clk);
        #1;
        got = '{ex_valid, ex_type, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc};
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s ex_regs: got v=%b t=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h required v=%b t=%0d rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h",
                     name, got.v, got.t, got.rd, got.rs1, got.rs2, got.imm, got.pc,
                     e.v, e.t, e.rd, e.rs1, e.rs2, e.imm, e.pc);
        end
        last_exp = e;
        $display("txn %-12s instr=%h pc=%h ex_stall=%b wb=%b/%0d stall=%b ex_valid=%b ex_type=%0d ex_pc=%h",
                 name, ins, pc, exs, wbv, wbr, stall, ex_valid, ex_type, ex_pc);
        wb_valid = 1'b0;
        ex_stall = 1'b0;
    endtask

    // Writeback of wreg that unblocks the instruction ins waiting in decode
    task automatic wb_release(input logic [31:0] ins, input logic [31:0] pc,
                              input logic [4:0] wreg, input string name);
`ifdef STAGE_DECODE_WB_BYPASS_EN
        step(ins, pc, 1'b0, 1'b1, wreg, 1'b0, K_ISSUE, name);
`else
        step(ins, pc, 1'b0, 1'b1, wreg, 1'b1, K_BUBBLE, name);
        step(ins, pc, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, name);
`endif
    endtask

    task automatic test_reset();
        logic [31:0] rnd;
        rnd = $urandom;
        rst = 1'b0;
        current_instruction = rnd;
        pc_in    = $urandom;
        ex_stall = 1'b0;
        wb_valid = 1'b1;
        wb_reg   = 5'd7;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ex_valid, ex_type, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_ex: got v=%b t=%0d pc=%h imm=%h required all zero", ex_valid, ex_type, ex_pc, ex_imm);
        end
        n_checks++;
        if ({stall, halted, illegal} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got stall=%b halted=%b illegal=%b required 000", stall, halted, illegal);
        end
        n_checks++;
        if (current_instruction_type !== rnd[4:0]) begin
            n_fail++;
            $display("FAIL reset_type: got %0d required %0d", current_instruction_type, rnd[4:0]);
        end
        rst      = 1'b1;
        wb_valid = 1'b0;
        wb_reg   = 5'd0;
        last_exp = '0;
        $display("txn reset       released");
    endtask

    task automatic test_raw();
        step(32'h0000_0061, 32'h100, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE,  "raw_wr3");
        step(32'h0000_0C21, 32'h101, 1'b0, 1'b0, 5'd0, 1'b1, K_BUBBLE, "raw_rd3");
        step(32'h0000_0C21, 32'h101, 1'b0, 1'b0, 5'd0, 1'b1, K_BUBBLE, "raw_rd3_b");
        wb_release(32'h0000_0C21, 32'h101, 5'd3, "raw_wb3");
        // WAW on r1, which the issued 0xC21 marked pending
        step(32'h0000_0021, 32'h102, 1'b0, 1'b0, 5'd0, 1'b1, K_BUBBLE, "waw_r1");
        wb_release(32'h0000_0021, 32'h102, 5'd1, "waw_wb1");
        // r1 pending again: the store reading r1 must wait
        step(32'h0000_0403, 32'h103, 1'b0, 1'b0, 5'd0, 1'b1, K_BUBBLE, "raw_st_r1");
        wb_release(32'h0000_0403, 32'h103, 5'd1, "raw_st_wb1");
        // r0 writes are never pending
        step(32'h0000_0001, 32'h104, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE,  "r0_wr");
        step(32'h0000_0001, 32'h105, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE,  "r0_rd");
    endtask

    task automatic test_ex_stall_hold();
        step(32'h1233_1441, 32'h200, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "hold_issue");
        step(32'h0000_0803, 32'h201, 1'b1, 1'b0, 5'd0, 1'b1, K_HOLD,  "hold_1");
        step(32'h0000_0803, 32'h201, 1'b1, 1'b1, 5'd2, 1'b1, K_HOLD,  "hold_2_wb2");
        step(32'h0000_0803, 32'h201, 1'b1, 1'b0, 5'd0, 1'b1, K_HOLD,  "hold_3");
        step(32'h0000_0803, 32'h201, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "hold_release");
    endtask

    task automatic test_imm_pc();
        step(32'hFFF0_0002, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "imm_neg_pc0");
        step(32'h7FF0_0003, 32'h0000_1000, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "imm_pos");
        step(32'h8004_2C84, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "jump_fields");
    endtask

    task automatic test_back_to_back();
        step(32'h0000_0081, 32'h300, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "b2b_alu_r4");
        step(32'h0000_00A2, 32'h301, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "b2b_ld_r5");
        step(32'h0000_1803, 32'h302, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "b2b_st_r6");
        step(32'h0000_1403, 32'h303, 1'b0, 1'b0, 5'd0, 1'b1, K_BUBBLE, "b2b_st_r5");
    endtask

    task automatic test_illegal();
        n_checks++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pre: got %b required 0", illegal);
        end
        step(32'h0000_0007, 32'h400, 1'b0, 1'b1, 5'd5, 1'b0, K_ISSUE, "illegal_7");
        n_checks++;
        if (illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_set: got %b required 1", illegal);
        end
        step(32'hFFFF_FFFF, 32'h401, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "illegal_31");
        step(32'h0000_0000, 32'h402, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "nop_after");
        n_checks++;
        if (illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_sticky: got %b required 1", illegal);
        end
    endtask

    task automatic test_halt();
        step(32'h0000_0005, 32'h500, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "halt_issue");
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_set: got %b required 1", halted);
        end
        step(32'h0000_0000, 32'h501, 1'b0, 1'b0, 5'd0, 1'b1, K_BUBBLE, "halt_nop");
        step(32'h0000_0000, 32'h501, 1'b0, 1'b1, 5'd4, 1'b1, K_BUBBLE, "halt_wb4");
        step(32'h0000_0000, 32'h501, 1'b0, 1'b0, 5'd0, 1'b1, K_BUBBLE, "halt_after");
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_sticky: got %b required 1", halted);
        end
        rst = 1'b0;
        #2;
        n_checks++;
        if ({halted, stall, illegal, ex_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL halt_reset: got halted=%b stall=%b illegal=%b ex_valid=%b required 0000",
                     halted, stall, illegal, ex_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_exp = '0;
        $display("txn reset       mid-halt cleared");
        step(32'h0000_00A2, 32'h600, 1'b0, 1'b0, 5'd0, 1'b0, K_ISSUE, "post_reset");
    endtask

    initial begin
        test_reset();
        test_raw();
        test_ex_stall_hold();
        test_imm_pc();
        test_back_to_back();
        test_illegal();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
